// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared data-memory port.
// Requester 0 is the core load/store unit, requester 1 the program/debug loader.
// Each access runs IDLE -> ISSUE (one strobe cycle) -> WAIT (MEM_LAT cycles);
// the completion pulse lands in the following IDLE cycle, so arbitration for the
// next access overlaps it. Every output is a flop.
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [2:0]  r0_type,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [2:0]  r1_type,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        r0_done,
    output logic        r1_done,
    output logic [31:0] r0_rdata,
    output logic [31:0] r1_rdata,
    output logic        mem_R_en,
    output logic        mem_W_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_RW_type,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t      state_q, state_n;
    logic        sel_q, sel_n;
    logic        last_q, last_n;
    logic        we_q, we_n;
    logic [2:0]  cnt_q, cnt_n;
    logic        win;

    logic        r0_gnt_n, r1_gnt_n, r0_done_n, r1_done_n;
    logic        mem_R_en_n, mem_W_en_n;
    logic [31:0] r0_rdata_n, r1_rdata_n, mem_addr_n, mem_wdata_n;
    logic [2:0]  mem_RW_type_n;

    // Next-state and next-output computation; outputs are registered below so
    // gnt/strobe appear in the ISSUE cycle and done in the cycle after WAIT ends.
    always_comb begin
        state_n       = state_q;
        sel_n         = sel_q;
        last_n        = last_q;
        we_n          = we_q;
        cnt_n         = cnt_q;
        r0_gnt_n      = 1'b0;
        r1_gnt_n      = 1'b0;
        r0_done_n     = 1'b0;
        r1_done_n     = 1'b0;
        mem_R_en_n    = 1'b0;
        mem_W_en_n    = 1'b0;
        r0_rdata_n    = r0_rdata;
        r1_rdata_n    = r1_rdata;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        mem_RW_type_n = mem_RW_type;
        // r1 wins when alone, or on a tie when r0 won most recently
        win           = r1_req & (~r0_req | ~last_q);

        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    sel_n         = win;
                    last_n        = win;
                    we_n          = win ? r1_we : r0_we;
                    mem_addr_n    = win ? r1_addr : r0_addr;
                    mem_wdata_n   = win ? r1_wdata : r0_wdata;
                    mem_RW_type_n = win ? r1_type : r0_type;
                    mem_R_en_n    = ~(win ? r1_we : r0_we);
                    mem_W_en_n    = win ? r1_we : r0_we;
                    r0_gnt_n      = ~win;
                    r1_gnt_n      = win;
                    state_n       = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = CNT_INIT;
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_n   = IDLE;
                    r0_done_n = ~sel_q;
                    r1_done_n = sel_q;
                    if (!we_q) begin
                        if (sel_q) r1_rdata_n = mem_rdata;
                        else       r0_rdata_n = mem_rdata;
                    end
                end else begin
                    cnt_n = cnt_q - 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            r0_gnt      <= 1'b0;
            r1_gnt      <= 1'b0;
            r0_done     <= 1'b0;
            r1_done     <= 1'b0;
            r0_rdata    <= '0;
            r1_rdata    <= '0;
            mem_R_en    <= 1'b0;
            mem_W_en    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_RW_type <= '0;
        end else begin
            state_q     <= state_n;
            sel_q       <= sel_n;
            last_q      <= last_n;
            we_q        <= we_n;
            cnt_q       <= cnt_n;
            r0_gnt      <= r0_gnt_n;
            r1_gnt      <= r1_gnt_n;
            r0_done     <= r0_done_n;
            r1_done     <= r1_done_n;
            r0_rdata    <= r0_rdata_n;
            r1_rdata    <= r1_rdata_n;
            mem_R_en    <= mem_R_en_n;
            mem_W_en    <= mem_W_en_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            mem_RW_type <= mem_RW_type_n;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (MEM_LAT = 1, 2, 4) share
// one stimulus stream; each scenario checks the instance whose latency it needs.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
    logic [31:0] r0_addr = '0, r1_addr = '0, r0_wdata = '0, r1_wdata = '0;
    logic [2:0]  r0_type = '0, r1_type = '0;
    logic [31:0] mem_rdata = 32'h0BADF00D;

    logic        a_r0_gnt, a_r1_gnt, a_r0_done, a_r1_done, a_R_en, a_W_en;
    logic [31:0] a_r0_rdata, a_r1_rdata, a_addr, a_wdata;
    logic [2:0]  a_type;
    logic        b_r0_gnt, b_r1_gnt, b_r0_done, b_r1_done, b_R_en, b_W_en;
    logic [31:0] b_r0_rdata, b_r1_rdata, b_addr, b_wdata;
    logic [2:0]  b_type;
    logic        c_r0_gnt, c_r1_gnt, c_r0_done, c_r1_done, c_R_en, c_W_en;
    logic [31:0] c_r0_rdata, c_r1_rdata, c_addr, c_wdata;
    logic [2:0]  c_type;

    int unsigned nerr = 0;
    int unsigned nchk = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_type(r0_type),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_type(r1_type),
        .r0_gnt(a_r0_gnt), .r1_gnt(a_r1_gnt), .r0_done(a_r0_done), .r1_done(a_r1_done),
        .r0_rdata(a_r0_rdata), .r1_rdata(a_r1_rdata), .mem_R_en(a_R_en), .mem_W_en(a_W_en),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_RW_type(a_type), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.MEM_LAT(2)) dut_b (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_type(r0_type),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_type(r1_type),
        .r0_gnt(b_r0_gnt), .r1_gnt(b_r1_gnt), .r0_done(b_r0_done), .r1_done(b_r1_done),
        .r0_rdata(b_r0_rdata), .r1_rdata(b_r1_rdata), .mem_R_en(b_R_en), .mem_W_en(b_W_en),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_RW_type(b_type), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.MEM_LAT(4)) dut_c (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_type(r0_type),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_type(r1_type),
        .r0_gnt(c_r0_gnt), .r1_gnt(c_r1_gnt), .r0_done(c_r0_done), .r1_done(c_r1_done),
        .r0_rdata(c_r0_rdata), .r1_rdata(c_r1_rdata), .mem_R_en(c_R_en), .mem_W_en(c_W_en),
        .mem_addr(c_addr), .mem_wdata(c_wdata), .mem_RW_type(c_type), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: returns 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        r0_type = '0; r1_type = '0;
        mem_rdata = 32'h0BADF00D;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Single read, MEM_LAT=2 (dut_b): gnt cycle 1, data valid cycle 3, done cycle 4
        do_reset();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h100;
        tick();
        check("rd_gnt0", 32'(b_r0_gnt), 32'd1);
        check("rd_gnt1", 32'(b_r1_gnt), 32'd0);
        check("rd_Ren", 32'(b_R_en), 32'd1);
        check("rd_Wen", 32'(b_W_en), 32'd0);
        check("rd_addr", b_addr, 32'h100);
        r0_req = 1'b0;
        tick();
        check("rd_strobe_off", 32'(b_R_en), 32'd0);
        check("rd_gnt_off", 32'(b_r0_gnt), 32'd0);
        tick();
        check("rd_no_early_done", 32'(b_r0_done), 32'd0);
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rdata = 32'h0BADF00D;
        check("rd_done0", 32'(b_r0_done), 32'd1);
        check("rd_done1", 32'(b_r1_done), 32'd0);
        check("rd_rdata", b_r0_rdata, 32'hDEADBEEF);
        tick();
        check("rd_done_pulse", 32'(b_r0_done), 32'd0);
        check("rd_rdata_hold", b_r0_rdata, 32'hDEADBEEF);

        // Reset state of dut_b (r0_rdata was non-zero before)
        do_reset();
        check("rst_r0_rdata", b_r0_rdata, 32'd0);
        check("rst_r1_rdata", b_r1_rdata, 32'd0);
        check("rst_gnt", {30'd0, b_r0_gnt, b_r1_gnt}, 32'd0);
        check("rst_done", {30'd0, b_r0_done, b_r1_done}, 32'd0);
        check("rst_strobes", {30'd0, b_R_en, b_W_en}, 32'd0);
        check("rst_addr", b_addr, 32'd0);
        check("rst_wdata", b_wdata, 32'd0);
        check("rst_type", 32'(b_type), 32'd0);

        // Write from r1, MEM_LAT=2 (dut_b); memory bus carries non-zero junk
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h40; r1_wdata = 32'h12345678; r1_type = 3'b010;
        mem_rdata = 32'hAAAA5555;
        tick();
        check("wr_gnt1", 32'(b_r1_gnt), 32'd1);
        check("wr_gnt0", 32'(b_r0_gnt), 32'd0);
        check("wr_Wen", 32'(b_W_en), 32'd1);
        check("wr_Ren", 32'(b_R_en), 32'd0);
        check("wr_addr", b_addr, 32'h40);
        check("wr_wdata", b_wdata, 32'h12345678);
        check("wr_type", 32'(b_type), 32'd2);
        r1_req = 1'b0;
        tick();
        check("wr_Wen_off", 32'(b_W_en), 32'd0);
        tick();
        tick();
        check("wr_done1", 32'(b_r1_done), 32'd1);
        check("wr_done0", 32'(b_r0_done), 32'd0);
        check("wr_rdata_unchanged", b_r1_rdata, 32'd0);

        // Contention, MEM_LAT=1 (dut_a): grants every 3 cycles, alternating r0/r1
        do_reset();
        r0_req = 1'b1; r0_addr = 32'h10;
        r1_req = 1'b1; r1_addr = 32'h20;
        for (int c = 1; c <= 24; c++) begin
            int ph;
            int k;
            logic g0, g1, d0, d1;
            tick();
            ph = c % 3;
            k  = c / 3;
            g0 = (ph == 1) && (k % 2 == 0);
            g1 = (ph == 1) && (k % 2 == 1);
            d0 = (ph == 0) && ((k - 1) % 2 == 0);
            d1 = (ph == 0) && ((k - 1) % 2 == 1);
            check($sformatf("cont_gnt0_c%0d", c), 32'(a_r0_gnt), 32'(g0));
            check($sformatf("cont_gnt1_c%0d", c), 32'(a_r1_gnt), 32'(g1));
            check($sformatf("cont_done0_c%0d", c), 32'(a_r0_done), 32'(d0));
            check($sformatf("cont_done1_c%0d", c), 32'(a_r1_done), 32'(d1));
            check($sformatf("cont_Ren_c%0d", c), 32'(a_R_en), 32'(ph == 1));
            check($sformatf("cont_Wen_c%0d", c), 32'(a_W_en), 32'd0);
            if (ph == 1)
                check($sformatf("cont_addr_c%0d", c), a_addr, g0 ? 32'h10 : 32'h20);
        end

        // Back-to-back from r0 alone, MEM_LAT=2 (dut_b): next gnt right after done
        do_reset();
        r0_req = 1'b1; r0_addr = 32'h80;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check($sformatf("b2b_gnt_c%0d", c), 32'(b_r0_gnt), 32'(c % 4 == 1));
            check($sformatf("b2b_done_c%0d", c), 32'(b_r0_done), 32'(c % 4 == 0));
        end

        // Reset in the second WAIT cycle, MEM_LAT=4 (dut_c)
        do_reset();
        r0_req = 1'b1; r0_addr = 32'h200; r0_type = 3'b101;
        tick();
        check("mr_gnt", 32'(c_r0_gnt), 32'd1);
        check("mr_addr", c_addr, 32'h200);
        r0_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mr_async_addr", c_addr, 32'd0);
        check("mr_async_type", 32'(c_type), 32'd0);
        check("mr_async_ctl", {26'd0, c_r0_gnt, c_r1_gnt, c_r0_done, c_r1_done, c_R_en, c_W_en}, 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("mr_no_done_c%0d", c), {30'd0, c_r0_done, c_r1_done}, 32'd0);
        end
        r0_req = 1'b1; r0_addr = 32'h300; r0_type = 3'b000;
        r1_req = 1'b1; r1_addr = 32'h304;
        tick();
        check("mr_tie_gnt0", 32'(c_r0_gnt), 32'd1);
        check("mr_tie_gnt1", 32'(c_r1_gnt), 32'd0);
        check("mr_tie_addr", c_addr, 32'h300);
        r0_req = 1'b0;
        r1_req = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("mr_tie_done", 32'(c_r0_done), 32'd1);

        // Idle hold: strobes stay low, address keeps last issued value
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("idle_strobes_c%0d", c), {30'd0, c_R_en, c_W_en}, 32'd0);
            check($sformatf("idle_addr_c%0d", c), c_addr, 32'h300);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single shared data-memory port. Sits between the core's load/store interface (requester 0) and the program/debug loader (requester 1) on one side and the data RAM on the other. It selects one request at a time with round-robin fairness, issues a one-cycle memory strobe, waits a fixed memory latency, and returns a registered completion pulse with read data to the winner.

## Interface
- `MEM_LAT`, default 1: cycles from the strobe cycle to the cycle `mem_rdata` is valid. Legal range is 1..8.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `r0_req`, `r1_req` in 1: access request. Held stable with its fields until the matching `gnt`.
- `r0_we`, `r1_we` in 1: 1 = write, 0 = read.
- `r0_addr`, `r1_addr` in 32: byte address.
- `r0_wdata`, `r1_wdata` in 32: write data.
- `r0_type`, `r1_type` in 3: access width/sign code. Passed through unchanged.
- `r0_gnt`, `r1_gnt` out 1: one-cycle pulse. Request accepted, fields latched.
- `r0_done`, `r1_done` out 1: one-cycle pulse. Access complete; for reads, `rN_rdata` is valid.
- `r0_rdata`, `r1_rdata` out 32: read data. Holds its value until the next read completes for that requester.
- `mem_R_en`, `mem_W_en` out 1: memory strobes.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_RW_type` out 3: memory command fields.
- `mem_rdata` in 32: memory read data.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: strobe, exactly one cycle.
  - WAIT: exactly `MEM_LAT` cycles.
- Reset values: state IDLE; every output 0, including both `rdata` registers and all `mem_*` fields; `last` = 1.
- `last` is the round-robin pointer: the index of the most recent winner.
- IDLE arbitration, on `rN_req` sampled at the clock edge:
  - Only one requester asserting: that requester wins.
  - Both asserting: the requester with index != `last` wins. The first tie after reset goes to r0.
  - Winner's we/addr/wdata/type are latched into the `mem_*` registers; `sel` and `last` are set to the winner; next state is ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - `rN_gnt` for `sel` is high.
  - Exactly one of `mem_R_en` / `mem_W_en` is high, according to the latched we.
  - The wait counter loads `MEM_LAT-1`; next state is WAIT.
- WAIT:
  - Strobes are low.
  - Counter decrements each cycle. At count 0, `mem_rdata` is sampled, next state is IDLE, and the `sel` `done` is registered high.
  - For a read, `rN_rdata[sel]` is loaded with `mem_rdata`. For a write, `rdata` is unchanged.
- The `done` cycle is an IDLE cycle, so arbitration runs in that same cycle.
  - A requester that wants no further access must drop `req` by then.
  - A `req` still high in that cycle is a new request.
- `mem_addr`, `mem_wdata`, `mem_RW_type` hold their last issued values between accesses. Only the strobes qualify them.
- At most one access is outstanding. The non-selected requester waits with `req` high and gets no `gnt`.
- Reset asserted in ISSUE or WAIT: the access is abandoned, no `done` is produced, and all outputs go to their reset values immediately (asynchronous).

## Timing
- Request sampled in cycle t (IDLE).
- `gnt` and strobe in cycle t+1.
- `mem_rdata` sampled at the end of cycle t+1+`MEM_LAT`.
- `done` and `rdata` in cycle t+2+`MEM_LAT`.
- Throughput: one access per `MEM_LAT`+2 cycles.
- Both requesters continuously requesting: grants strictly alternate r0, r1, r0, …
- `gnt` and `done` never assert for both requesters in the same cycle. The strobes are never asserted outside ISSUE.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
- Single read, `MEM_LAT`=2: r0 reads address 0x100; memory returns 0xDEADBEEF in the valid cycle → `r0_gnt` in cycle 1 with `mem_R_en`=1 and `mem_addr`=0x100; `r0_done` in cycle 4 with `r0_rdata`=0xDEADBEEF.
- Write: r1 writes 0x12345678 to 0x40 with type 3'b010 → `mem_W_en`=1 with matching `mem_wdata`, `mem_addr` and `mem_RW_type` for one cycle; `r1_done` pulses; `r1_rdata` is unchanged.
- Contention, `MEM_LAT`=1: both requesters hold `req` for 4 accesses each → grant order r0, r1, r0, r1, …; accesses issue every 3 cycles; no cycle has both strobes or both `gnt` high.
- Back-to-back: r0 keeps `req` high through its `done` cycle → the next `r0_gnt` follows exactly one cycle after `done`.
- Reset mid-WAIT (`MEM_LAT`=4): assert `rst` in the second WAIT cycle → all outputs 0 immediately, no `done` afterwards; the first tie after reset goes to r0.
- Idle hold: no requests for 20 cycles → strobes stay 0; `mem_addr` keeps the last issued address.
